// File: rtl/bram_accumulator_ctrl_pkg.sv
// Shared definitions for the BRAM accumulator controller slice.
package bram_accumulator_ctrl_pkg;

    // Ceiling log2, usable in parameter expressions.
    function automatic int LOG2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bram_accumulator_ctrl_block_ram.sv
// Simple dual-port block RAM: writes on every enabled cycle, registered read
// returning the pre-write contents.
module block_ram
    import bram_accumulator_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SIZE  = 256,
    localparam int AW   = LOG2(SIZE)
) (
    input  logic             clk,
    input  logic             clk_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data
);

    logic [WIDTH-1:0] mem [SIZE];

    always_ff @(posedge clk) begin
        if (clk_en) begin
            mem[wr_addr] <= wr_data;
            rd_data      <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/bram_accumulator_ctrl.sv
// Read-modify-write accumulator over one block_ram, shared by two requesters
// and a read-and-clear dump sweep.
module bram_accumulator_ctrl
    import bram_accumulator_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SIZE  = 256,
    localparam int AW   = LOG2(SIZE)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_en,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [AW-1:0]    req0_addr,
    input  logic [WIDTH-1:0] req0_value,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [AW-1:0]    req1_addr,
    input  logic [WIDTH-1:0] req1_value,
    input  logic             dump_start,
    output logic             busy,
    output logic             dump_valid,
    output logic [AW-1:0]    dump_addr,
    output logic [WIDTH-1:0] dump_data,
    output logic             dump_last
);

    typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_DUMP} state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(SIZE - 1);

    state_t           state, state_next;
    logic [AW-1:0]    sweep_cnt;
    logic             sweep_done;
    logic             dv;
    logic [AW-1:0]    dv_addr;
    logic             dump_last_beat;
    logic             rr_ptr;
    logic             grant1;
    logic             accept;
    logic             contended;
    logic             dump_go;
    logic             p_valid;
    logic [AW-1:0]    p_addr;
    logic [WIDTH-1:0] p_value;
    logic             f_valid;
    logic [AW-1:0]    f_addr;
    logic [WIDTH-1:0] f_sum;
    logic [WIDTH-1:0] op_base;
    logic [WIDTH-1:0] op_sum;
    logic [AW-1:0]    last_addr;
    logic [WIDTH-1:0] last_data;
    logic [AW-1:0]    ram_rd_addr;
    logic [AW-1:0]    ram_wr_addr;
    logic [WIDTH-1:0] ram_rd_data;
    logic [WIDTH-1:0] ram_wr_data;

    block_ram #(
        .WIDTH (WIDTH),
        .SIZE  (SIZE)
    ) u_ram (
        .clk     (clk),
        .clk_en  (clk_en),
        .rd_addr (ram_rd_addr),
        .rd_data (ram_rd_data),
        .wr_addr (ram_wr_addr),
        .wr_data (ram_wr_data)
    );

    assign contended      = req0_valid & req1_valid;
    assign accept         = req0_ready | req1_ready;
    assign dump_last_beat = dv & (dv_addr == LAST_ADDR);

    // A dump request wins over both requesters in the cycle it is seen.
    always_comb begin
        state_next  = state;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        grant1      = 1'b0;
        dump_go     = 1'b0;
        ram_rd_addr = sweep_cnt;
        case (state)
            ST_INIT: begin
                if (sweep_cnt == LAST_ADDR) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (dump_start) begin
                    dump_go    = 1'b1;
                    state_next = ST_DUMP;
                end else begin
                    grant1      = req1_valid & (~req0_valid | rr_ptr);
                    req0_ready  = req0_valid & ~grant1;
                    req1_ready  = grant1;
                    ram_rd_addr = grant1 ? req1_addr : req0_addr;
                end
            end
            ST_DUMP: begin
                if (dump_last_beat) begin
                    state_next = ST_RUN;
                end
            end
            default: state_next = ST_INIT;
        endcase
    end

    // Back-to-back ops on one address would read stale RAM data, so the
    // previous sum is forwarded instead.
    assign op_base = (f_valid && (f_addr == p_addr)) ? f_sum : ram_rd_data;
    assign op_sum  = op_base + p_value;

    // The RAM always writes; with nothing real to write, the last pair is replayed.
    always_comb begin
        ram_wr_addr = last_addr;
        ram_wr_data = last_data;
        if (state == ST_INIT) begin
            ram_wr_addr = sweep_cnt;
            ram_wr_data = '0;
        end else if (p_valid) begin
            ram_wr_addr = p_addr;
            ram_wr_data = op_sum;
        end else if (dv) begin
            ram_wr_addr = dv_addr;
            ram_wr_data = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_INIT;
            sweep_cnt  <= '0;
            sweep_done <= 1'b0;
            dv         <= 1'b0;
            dv_addr    <= '0;
        end else if (clk_en) begin
            state <= state_next;
            dv    <= (state == ST_DUMP) && !sweep_done;
            if ((state == ST_DUMP) && !sweep_done) begin
                dv_addr <= sweep_cnt;
            end
            case (state)
                ST_INIT: begin
                    if (sweep_cnt != LAST_ADDR) begin
                        sweep_cnt <= sweep_cnt + AW'(1);
                    end
                end
                ST_RUN: begin
                    if (dump_go) begin
                        sweep_cnt  <= '0;
                        sweep_done <= 1'b0;
                    end
                end
                ST_DUMP: begin
                    if (!sweep_done) begin
                        if (sweep_cnt == LAST_ADDR) begin
                            sweep_done <= 1'b1;
                        end else begin
                            sweep_cnt <= sweep_cnt + AW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr    <= 1'b0;
            p_valid   <= 1'b0;
            p_addr    <= '0;
            p_value   <= '0;
            f_valid   <= 1'b0;
            f_addr    <= '0;
            f_sum     <= '0;
            last_addr <= '0;
            last_data <= '0;
        end else if (clk_en) begin
            p_valid <= accept;
            if (accept) begin
                p_addr  <= grant1 ? req1_addr : req0_addr;
                p_value <= grant1 ? req1_value : req0_value;
            end
            if (accept && contended) begin
                rr_ptr <= ~rr_ptr;
            end
            f_valid   <= p_valid;
            f_addr    <= p_addr;
            f_sum     <= op_sum;
            last_addr <= ram_wr_addr;
            last_data <= ram_wr_data;
        end
    end

    assign busy       = (state != ST_RUN);
    assign dump_valid = dv;
    assign dump_addr  = dv_addr;
    assign dump_data  = dv ? ram_rd_data : '0;
    assign dump_last  = dump_last_beat;

endmodule

// File: tb/tb_bram_accumulator_ctrl.sv
// Directed self-checking bench for bram_accumulator_ctrl: vector table for
// arbitration/forwarding plus hand-written dump, reset and wrap sequences.
module tb_bram_accumulator_ctrl;

    localparam int WIDTH = 32;
    localparam int SIZE  = 256;
    localparam int AW    = 8;

    logic             clk;
    logic             reset;
    logic             clk_en;
    logic             req0_valid;
    logic             req0_ready;
    logic [AW-1:0]    req0_addr;
    logic [WIDTH-1:0] req0_value;
    logic             req1_valid;
    logic             req1_ready;
    logic [AW-1:0]    req1_addr;
    logic [WIDTH-1:0] req1_value;
    logic             dump_start;
    logic             busy;
    logic             dump_valid;
    logic [AW-1:0]    dump_addr;
    logic [WIDTH-1:0] dump_data;
    logic             dump_last;

    int               n_checks;
    int               n_fails;
    logic [WIDTH-1:0] dump_mem [SIZE];

    typedef struct {
        string            name;
        logic             v0;
        logic [AW-1:0]    a0;
        logic [WIDTH-1:0] d0;
        logic             v1;
        logic [AW-1:0]    a1;
        logic [WIDTH-1:0] d1;
        logic             r0;
        logic             r1;
    } vec_t;

    vec_t vecs [9];

    bram_accumulator_ctrl #(
        .WIDTH (WIDTH),
        .SIZE  (SIZE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .clk_en     (clk_en),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_addr  (req0_addr),
        .req0_value (req0_value),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_addr  (req1_addr),
        .req1_value (req1_value),
        .dump_start (dump_start),
        .busy       (busy),
        .dump_valid (dump_valid),
        .dump_addr  (dump_addr),
        .dump_data  (dump_data),
        .dump_last  (dump_last)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        req0_valid = v.v0;
        req0_addr  = v.a0;
        req0_value = v.d0;
        req1_valid = v.v1;
        req1_addr  = v.a1;
        req1_value = v.d1;
        #1;
    endtask

    task automatic accumulate0(input logic [AW-1:0] addr, input logic [WIDTH-1:0] value);
        req0_valid = 1'b1;
        req0_addr  = addr;
        req0_value = value;
        tick();
        req0_valid = 1'b0;
    endtask

    function automatic int nonzeroCount();
        int n;
        n = 0;
        for (int i = 0; i < SIZE; i++) begin
            if (dump_mem[i] !== '0) n++;
        end
        return n;
    endfunction

    // Counts INIT cycles from the current one, with req0 held valid throughout.
    task automatic waitInit(input string tag);
        int n;
        int rdy;
        n   = 0;
        rdy = 0;
        req0_valid = 1'b1;
        req0_addr  = 8'd0;
        req0_value = 32'd0;
        #1;
        while (busy === 1'b1 && n < 1000) begin
            if (req0_ready === 1'b1) rdy++;
            n++;
            tick();
        end
        checkOutput({tag, "_busy_cycles"}, 32'(n), 32'(SIZE));
        checkOutput({tag, "_ready_in_init"}, 32'(rdy), 32'd0);
        checkOutput({tag, "_first_run_ready"}, 32'(req0_ready), 32'd1);
        req0_valid = 1'b0;
        #1;
    endtask

    task automatic runDump(input string tag);
        int c;
        int beats;
        int lasts;
        int last_at;
        int first_c;
        int seq_err;
        for (int i = 0; i < SIZE; i++) dump_mem[i] = 32'hDEADBEEF;
        dump_start = 1'b1;
        req0_valid = 1'b1;
        req0_addr  = 8'd50;
        req0_value = 32'd100;
        req1_valid = 1'b1;
        req1_addr  = 8'd50;
        req1_value = 32'd100;
        #1;
        checkOutput({tag, "_start_readies"}, 32'({req0_ready, req1_ready}), 32'd0);
        tick();
        dump_start = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        c       = 1;
        beats   = 0;
        lasts   = 0;
        last_at = -1;
        first_c = -1;
        seq_err = 0;
        while (busy === 1'b1 && c < SIZE + 20) begin
            if (dump_valid === 1'b1) begin
                if (first_c < 0) first_c = c;
                if (int'(dump_addr) != beats) seq_err++;
                dump_mem[dump_addr] = dump_data;
                if (dump_last === 1'b1) begin
                    lasts++;
                    last_at = int'(dump_addr);
                end
                beats++;
            end else if (dump_last !== 1'b0) begin
                seq_err++;
            end
            tick();
            c++;
        end
        checkOutput({tag, "_run_resume_cycle"}, 32'(c), 32'(SIZE + 2));
        checkOutput({tag, "_first_valid_cycle"}, 32'(first_c), 32'd2);
        checkOutput({tag, "_beats"}, 32'(beats), 32'(SIZE));
        checkOutput({tag, "_addr_sequence_errors"}, 32'(seq_err), 32'd0);
        checkOutput({tag, "_last_count"}, 32'(lasts), 32'd1);
        checkOutput({tag, "_last_addr"}, 32'(last_at), 32'(SIZE - 1));
    endtask

    initial begin
        int found;
        n_checks   = 0;
        n_fails    = 0;
        reset      = 1'b1;
        clk_en     = 1'b1;
        req0_valid = 1'b1;
        req0_addr  = '0;
        req0_value = '0;
        req1_valid = 1'b0;
        req1_addr  = '0;
        req1_value = '0;
        dump_start = 1'b0;

        vecs[0] = '{"fwd_op1",  1'b1, 8'd7, 32'd1, 1'b0, 8'd0, 32'd0, 1'b1, 1'b0};
        vecs[1] = '{"fwd_op2",  1'b1, 8'd7, 32'd2, 1'b0, 8'd0, 32'd0, 1'b1, 1'b0};
        vecs[2] = '{"fwd_op3",  1'b1, 8'd7, 32'd3, 1'b0, 8'd0, 32'd0, 1'b1, 1'b0};
        vecs[3] = '{"req1_only", 1'b0, 8'd0, 32'd0, 1'b1, 8'd9, 32'd4, 1'b0, 1'b1};
        vecs[4] = '{"rr_grant0", 1'b1, 8'd0, 32'd1, 1'b1, 8'd1, 32'd1, 1'b1, 1'b0};
        vecs[5] = '{"rr_grant1", 1'b1, 8'd0, 32'd1, 1'b1, 8'd1, 32'd1, 1'b0, 1'b1};
        vecs[6] = '{"rr_grant2", 1'b1, 8'd0, 32'd1, 1'b1, 8'd1, 32'd1, 1'b1, 1'b0};
        vecs[7] = '{"rr_grant3", 1'b1, 8'd0, 32'd1, 1'b1, 8'd1, 32'd1, 1'b0, 1'b1};
        vecs[8] = '{"idle",      1'b0, 8'd0, 32'd0, 1'b0, 8'd0, 32'd0, 1'b0, 1'b0};

        tick();
        tick();
        checkOutput("reset_busy", 32'(busy), 32'd1);
        checkOutput("reset_dump_valid", 32'(dump_valid), 32'd0);
        checkOutput("reset_dump_last", 32'(dump_last), 32'd0);
        checkOutput("reset_dump_addr", 32'(dump_addr), 32'd0);
        checkOutput("reset_dump_data", dump_data, 32'd0);
        checkOutput("reset_readies", 32'({req0_ready, req1_ready}), 32'd0);
        reset = 1'b0;
        waitInit("init");

        runDump("dump_zero");
        checkOutput("dump_zero_nonzero", 32'(nonzeroCount()), 32'd0);

        req0_valid = 1'b1;
        req0_addr  = 8'd3;
        req0_value = 32'd5;
        #1;
        checkOutput("single_ready0", 32'(req0_ready), 32'd1);
        tick();
        req0_valid = 1'b0;
        runDump("dump_single");
        checkOutput("single_addr3", dump_mem[3], 32'd5);
        checkOutput("single_nonzero", 32'(nonzeroCount()), 32'd1);

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i].name, 32'({req0_ready, req1_ready}), 32'({vecs[i].r0, vecs[i].r1}));
            tick();
        end
        runDump("dump_table");
        checkOutput("fwd_addr7", dump_mem[7], 32'd6);
        checkOutput("req1_addr9", dump_mem[9], 32'd4);
        checkOutput("rr_addr0", dump_mem[0], 32'd2);
        checkOutput("rr_addr1", dump_mem[1], 32'd2);
        checkOutput("table_nonzero", 32'(nonzeroCount()), 32'd4);

        accumulate0(8'd0, 32'd9);
        runDump("dump_after_accept");
        checkOutput("late_accept_addr0", dump_mem[0], 32'd9);
        checkOutput("late_accept_nonzero", 32'(nonzeroCount()), 32'd1);
        runDump("dump_cleared");
        checkOutput("cleared_nonzero", 32'(nonzeroCount()), 32'd0);

        accumulate0(8'd200, 32'h55);
        tick();
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        found = 0;
        for (int i = 0; i < SIZE + 10; i++) begin
            if (dump_valid === 1'b1 && dump_addr == 8'd100) begin
                found = 1;
                break;
            end
            tick();
        end
        checkOutput("mid_dump_reached_k100", 32'(found), 32'd1);
        reset = 1'b1;
        tick();
        checkOutput("mid_dump_reset_valid", 32'(dump_valid), 32'd0);
        checkOutput("mid_dump_reset_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        waitInit("reinit");
        runDump("dump_after_reinit");
        checkOutput("reinit_nonzero", 32'(nonzeroCount()), 32'd0);

        accumulate0(8'd1, 32'hFFFF_FFFF);
        accumulate0(8'd1, 32'd2);
        accumulate0(8'd2, 32'hFFFF_FFFE);
        tick();
        accumulate0(8'd2, 32'd3);
        clk_en     = 1'b0;
        req0_valid = 1'b1;
        req0_addr  = 8'd5;
        req0_value = 32'd7;
        tick();
        tick();
        tick();
        clk_en = 1'b1;
        tick();
        req0_valid = 1'b0;
        tick();
        tick();
        runDump("dump_wrap");
        checkOutput("wrap_addr1", dump_mem[1], 32'd1);
        checkOutput("wrap_addr2", dump_mem[2], 32'd1);
        checkOutput("clk_en_addr5", dump_mem[5], 32'd7);
        checkOutput("wrap_nonzero", 32'(nonzeroCount()), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/bram_accumulator_ctrl.md
# bram_accumulator_ctrl

Read-modify-write controller that owns one `block_ram` instance and shares it between two accumulate requesters plus a read-and-clear dump sweep. Each accepted request adds a value to the word at an address. The block hides the RAM's unconditional write-on-enable behaviour and its one-cycle read latency from all clients. It sits between the producers of per-address increments and the consumer that periodically drains the accumulated totals.

## Interface
- `WIDTH`, 32, data/value width in bits
- `SIZE`, 256, number of RAM words; address width `AW = LOG2(SIZE)`

- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `clk_en`  in  1  global enable; when low, all state, outputs and RAM hold
- `req0_valid`/`req1_valid`  in  1  accumulate request from requester 0/1
- `req0_ready`/`req1_ready`  out  1  request accepted this cycle (when valid&ready&clk_en)
- `req0_addr`/`req1_addr`  in  AW  target word
- `req0_value`/`req1_value`  in  WIDTH  increment
- `dump_start`  in  1  request a read-and-clear sweep (single-cycle pulse)
- `busy`  out  1  high in INIT and DUMP
- `dump_valid`  out  1  `dump_data` valid this cycle; no backpressure
- `dump_addr`  out  AW  address of `dump_data`
- `dump_data`  out  WIDTH  accumulated value prior to clearing
- `dump_last`  out  1  with `dump_valid` on address SIZE-1

## Operation
- States: INIT -> RUN -> DUMP -> RUN.
  - INIT: write 0 to addresses 0..SIZE-1, one per enabled cycle, then go to RUN.
  - RUN: service accumulate requests.
  - DUMP: sweep all addresses.
- The RAM writes on every enabled cycle. Whenever no real write is pending, the block replays the last written (addr, data) pair. The replay registers reset to (0, 0), which is legal because INIT clears the RAM.
- Arbitration in RUN: at most one `reqN_ready` is high per cycle.
  - Only one valid: grant it.
  - Both valid: round-robin. The pointer resets to requester 0 and flips after each contended grant.
  - Ready is high only for the granted valid requester.
- Accumulate pipeline:
  - Accept cycle t: `rd_addr = addr`.
  - Cycle t+1: `wr_addr = addr`, `wr_data = (rd_data + value) mod 2^WIDTH`.
  - Full throughput: one op per cycle.
- Forwarding: if the op accepted at t+1 has the same address as the op at t, it uses the t op's computed sum instead of `rd_data`. This avoids the RAM's read-old-data hazard.
- `dump_start` in RUN:
  - Takes priority over requests; both readies are low that cycle.
  - Any op in flight completes its write in that cycle; the next cycle enters DUMP.
  - `dump_start` in INIT or DUMP is ignored.
- DUMP, sweep cycle k (0..SIZE-1): read address k.
  - In cycle k+1: present `dump_valid`, `dump_addr = k`, `dump_data = rd_data`, and write 0 to address k.
  - After `dump_last`, return to RUN.
- Reset outputs: `reqN_ready = 0`, `busy = 1` (INIT), `dump_valid = 0`, `dump_last = 0`, `dump_addr = 0`, `dump_data = 0`, and the arbiter pointer is 0.

## Timing
- After `reset` deasserts: SIZE enabled cycles of INIT. First ready can be high in the following cycle.
- Accumulate latency: accept at t, RAM updated at edge ending t+1. A read by the next op at t+1 sees the correct value via forwarding.
- Dump, with `dump_start` at cycle s:
  - DUMP occupies cycles s+1..s+SIZE+1.
  - `dump_valid` is high s+2..s+SIZE+1.
  - RUN, with readies allowed, resumes at s+SIZE+2.
- `clk_en` low: freeze; `ram_clk_en` = `clk_en`, and no handshake completes.
- Reset mid-INIT, mid-DUMP or mid-op: in-flight work is discarded, `dump_valid` drops next cycle, and INIT restarts from address 0.
- Address wrap: INIT and DUMP counters stop at SIZE-1. Sum overflow wraps modulo 2^WIDTH with no flag.

## Structure
- `LOG2` comes from the shared definitions header.
- State encodings are local parameters; nothing new goes into the shared header.
- One sub-module: `block_ram #(WIDTH, SIZE)`, instantiated internally. Its `clk_en` is tied to the block's `clk_en`.

## Test plan
- Reset, then wait: `busy` high exactly SIZE cycles. A subsequent dump returns all zeros with `dump_last` on address 255.
- req0 adds 5 to addr 3, then a dump: `dump_data` = 5 at `dump_addr` 3, and all other words are 0.
- req0 adds 1, 2, 3 to addr 7 on consecutive cycles (forwarding): dump shows 6 at addr 7.
- Both requesters valid continuously for 4 cycles: grants alternate 0, 1, 0, 1. Each adds 1 to addr 0 and 1 respectively; dump shows 2 and 2.
- `dump_start` pulsed the cycle after an accept to addr 0 with value 9: `dump_data[0]` = 9. A second dump shows 0 (cleared).
- Reset asserted mid-dump at k=100: `dump_valid` drops, INIT reruns. A following dump is all zeros.
- Add 0xFFFFFFFF then 2 to addr 1: dump shows 1 (wrap).
